xcvr_rcfg_streamer: RTL and testbench

Parametrised multi-channel, multi-profile reconfiguration streamer for the transceiver PHY reconfiguration interface. On a load request it locates the selected profile in an external configuration ROM of 26-bit entries (10-bit register address, 8-bit mask, 8-bit data, profiles terminated by 26'h3FFFFFF). It then applies every entry as a read-modify-write to each selected channel over the Avalon-MM reconfiguration master. It sits between the user/system control logic and the shared PHY reconfig port, replacing per-IP fixed-profile streamers.

---
 rtl/xcvr_rcfg_strm_pkg.sv | 35 +++
 rtl/xcvr_rcfg_ch_next.sv | 25 ++
 rtl/xcvr_rcfg_streamer.sv | 217 +++++++++++++++++++++
 tb/tb_xcvr_rcfg_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_rcfg_strm_pkg.sv
// rtl/xcvr_rcfg_strm_pkg.sv - shared types, constants and merge helper for the reconfig streamer
package xcvr_rcfg_strm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EVAL,
        ST_RD,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] mask;
        logic [7:0] data;
    } entry_t;

    localparam int ENTRY_W  = 26;
    localparam int ADDR_LSB = 16;
    localparam int MASK_LSB = 8;
    localparam int DATA_LSB = 0;

    localparam logic [ENTRY_W-1:0] END_MARKER = 26'h3FFFFFF;
    localparam logic [7:0]         FULL_MASK  = 8'hFF;

    // Only the low byte is touched; the upper readback bits are written back unchanged.
    function automatic logic [31:0] rmw_merge(input logic [31:0] rd,
                                              input logic [7:0]  mask,
                                              input logic [7:0]  data);
        return {rd[31:8], (rd[7:0] & ~mask) | (data & mask)};
    endfunction

endpackage

// File: rtl/xcvr_rcfg_ch_next.sv
// rtl/xcvr_rcfg_ch_next.sv - finds the lowest set channel bit above idx (or from bit 0)
module xcvr_rcfg_ch_next #(
    parameter  int CHANNELS = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [CH_W-1:0]     idx,
    input  logic                from_start,
    output logic [CH_W-1:0]     nxt,
    output logic                found
);

    // Descending scan so the last hit written is the lowest qualifying bit.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(idx)))) begin
                found = 1'b1;
                nxt   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/xcvr_rcfg_streamer.sv
// rtl/xcvr_rcfg_streamer.sv - streams a ROM profile as read-modify-writes to selected PHY channels
module xcvr_rcfg_streamer
    import xcvr_rcfg_strm_pkg::*;
#(
    parameter  int CHANNELS      = 1,
    parameter  int PROFILES      = 2,
    parameter  int ROM_DEPTH     = 4,
    parameter  int TIMEOUT       = 1024,
    parameter  int SKIP_FULL_RMW = 1,
    localparam int SEL_W  = (PROFILES > 1) ? $clog2(PROFILES) : 1,
    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MA_W   = (CHANNELS > 1) ? 10 + $clog2(CHANNELS) : 10
) (
    input  logic                reconfig_clk,
    input  logic                reconfig_reset_n,
    input  logic                cfg_load,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CHANNELS-1:0] cfg_ch_mask,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_error,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [25:0]         rom_rdata,
    output logic [MA_W-1:0]     mgmt_address,
    output logic                mgmt_read,
    output logic                mgmt_write,
    output logic [31:0]         mgmt_writedata,
    input  logic [31:0]         mgmt_readdata,
    input  logic                mgmt_waitrequest
);

    localparam int PTR_W = ROM_AW + 1;
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0]   PROF_N   = (SEL_W + 1)'(PROFILES);
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(ROM_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t                state, state_next;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      pcnt;
    logic [CHANNELS-1:0]   mask_q;
    logic [PTR_W-1:0]      ptr;
    entry_t                entry_q;
    logic [CH_W-1:0]       ch_q;
    logic [31:0]           rd_q;
    logic [TO_W-1:0]       stall_cnt;
    logic                  err_q;

    entry_t                rom_entry;
    logic                  is_marker;
    logic                  seeking;
    logic                  sel_bad;
    logic                  wo_eval;
    logic                  wo_q;
    logic                  in_access;
    logic                  to_hit;
    logic [CH_W-1:0]       nxt_ch;
    logic                  nxt_found;
    logic [MA_W-1:0]       addr_full;

    assign rom_entry = entry_t'(rom_rdata);
    assign is_marker = (rom_rdata == END_MARKER);
    assign seeking   = (pcnt < sel_q);
    assign sel_bad   = ({1'b0, cfg_sel} >= PROF_N);
    assign wo_eval   = (SKIP_FULL_RMW != 0) && (rom_entry.mask == FULL_MASK);
    assign wo_q      = (SKIP_FULL_RMW != 0) && (entry_q.mask == FULL_MASK);
    assign in_access = (state == ST_RD) || (state == ST_WR);
    assign to_hit    = (TIMEOUT != 0) && in_access && mgmt_waitrequest && (stall_cnt == TO_LAST);

    xcvr_rcfg_ch_next #(
        .CHANNELS (CHANNELS)
    ) u_ch_next (
        .mask       (mask_q),
        .idx        (ch_q),
        .from_start (state == ST_EVAL),
        .nxt        (nxt_ch),
        .found      (nxt_found)
    );

    generate
        if (CHANNELS > 1) begin : g_multi
            assign addr_full = {ch_q, entry_q.addr};
        end else begin : g_single
            assign addr_full = entry_q.addr;
        end
    endgenerate

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_load) begin
                    state_next = (sel_bad || (cfg_ch_mask == '0)) ? ST_ERR : ST_FETCH;
                end
            end
            ST_FETCH: state_next = (ptr == PTR_END) ? ST_ERR : ST_EVAL;
            ST_EVAL: begin
                if (seeking) begin
                    state_next = ST_FETCH;
                end else if (is_marker) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = wo_eval ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                if (to_hit) begin
                    state_next = ST_ERR;
                end else if (!mgmt_waitrequest) begin
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                if (to_hit) begin
                    state_next = ST_ERR;
                end else if (!mgmt_waitrequest) begin
                    if (nxt_found) begin
                        state_next = wo_q ? ST_WR : ST_RD;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_busy       = (state != ST_IDLE);
        cfg_done       = (state == ST_DONE) || (state == ST_ERR);
        cfg_error      = err_q;
        rom_addr       = ptr[ROM_AW-1:0];
        mgmt_read      = (state == ST_RD);
        mgmt_write     = (state == ST_WR);
        mgmt_address   = in_access ? addr_full : '0;
        mgmt_writedata = '0;
        if (state == ST_WR) begin
            mgmt_writedata = wo_q ? {24'h0, entry_q.data}
                                  : rmw_merge(rd_q, entry_q.mask, entry_q.data);
        end
    end

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            sel_q     <= '0;
            pcnt      <= '0;
            mask_q    <= '0;
            ptr       <= '0;
            entry_q   <= '0;
            ch_q      <= '0;
            rd_q      <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            // Counts consecutive stalled cycles of the current access only.
            if (in_access && mgmt_waitrequest && (TIMEOUT != 0)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        sel_q  <= cfg_sel;
                        mask_q <= cfg_ch_mask;
                        ptr    <= '0;
                        pcnt   <= '0;
                        err_q  <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    if (seeking) begin
                        if (is_marker) begin
                            pcnt <= pcnt + 1'b1;
                        end
                        ptr <= ptr + 1'b1;
                    end else if (!is_marker) begin
                        entry_q <= rom_entry;
                        ch_q    <= nxt_ch;
                    end
                end
                ST_RD: begin
                    if (!mgmt_waitrequest) begin
                        rd_q <= mgmt_readdata;
                    end
                end
                ST_WR: begin
                    if (!mgmt_waitrequest) begin
                        if (nxt_found) begin
                            ch_q <= nxt_ch;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (state_next == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xcvr_rcfg_streamer.sv
// tb/tb_xcvr_rcfg_streamer.sv - directed self-checking bench for xcvr_rcfg_streamer
module tb_xcvr_rcfg_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load;
    logic [1:0]  cfg_sel;
    logic [3:0]  cfg_ch_mask;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [1:0]  rom_addr;
    logic [25:0] rom_rdata;
    logic [11:0] mgmt_address;
    logic        mgmt_read, mgmt_write;
    logic [31:0] mgmt_writedata, mgmt_readdata;
    logic        mgmt_waitrequest;

    logic [25:0] rom [4];

    always #5 clk = ~clk;

    xcvr_rcfg_streamer #(
        .CHANNELS      (4),
        .PROFILES      (3),
        .ROM_DEPTH     (4),
        .TIMEOUT       (16),
        .SKIP_FULL_RMW (1)
    ) dut (
        .reconfig_clk     (clk),
        .reconfig_reset_n (rst_n),
        .cfg_load         (cfg_load),
        .cfg_sel          (cfg_sel),
        .cfg_ch_mask      (cfg_ch_mask),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_error        (cfg_error),
        .rom_addr         (rom_addr),
        .rom_rdata        (rom_rdata),
        .mgmt_address     (mgmt_address),
        .mgmt_read        (mgmt_read),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    always @(posedge clk) rom_rdata <= rom[rom_addr];
    assign mgmt_readdata = 32'h000000A5;

    int          rd_acc = 0, rd_hi = 0, done_cnt = 0;
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        if (mgmt_read) rd_hi++;
        if (mgmt_read && !mgmt_waitrequest) rd_acc++;
        if (mgmt_write && !mgmt_waitrequest) begin
            wa_q.push_back(mgmt_address);
            wd_q.push_back(mgmt_writedata);
        end
        if (cfg_done) done_cnt++;
    end

    int n_chk = 0, n_pass = 0;
    int b_acc, b_hi, b_done, b_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic snap();
        b_acc  = rd_acc;
        b_hi   = rd_hi;
        b_done = done_cnt;
        b_w    = wa_q.size();
    endtask

    task automatic rom_rmw();
        rom[0] = 26'h1080704; rom[1] = 26'h3FFFFFF;
        rom[2] = 26'h1080703; rom[3] = 26'h3FFFFFF;
    endtask

    task automatic rom_wo();
        rom[0] = 26'h10AFF3C; rom[1] = 26'h3FFFFFF;
        rom[2] = 26'h3FFFFFF; rom[3] = 26'h3FFFFFF;
    endtask

    // lat counts cycles from the load cycle through the done cycle inclusive.
    task automatic run(input logic [1:0] sel, input logic [3:0] mask, input bit poke,
                       output int lat, output logic err, output logic busy0);
        int n;
        bit seen;
        @(negedge clk);
        cfg_sel = sel; cfg_ch_mask = mask; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        busy0 = cfg_busy;
        n = 0; seen = 0;
        while (n < 200 && !seen) begin
            if (cfg_done) seen = 1;
            else begin
                if (poke && n == 1) cfg_load = 1'b1;
                @(negedge clk);
                cfg_load = 1'b0;
                n++;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        lat = n + 2;
        err = cfg_error;
    endtask

    int   lat;
    logic err, busy0;

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_sel = '0; cfg_ch_mask = '0;
        mgmt_waitrequest = 1'b0;
        rom_rmw();
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, cfg_busy},  32'd0);
        check("rst_done",  {31'd0, cfg_done},  32'd0);
        check("rst_error", {31'd0, cfg_error}, 32'd0);
        check("rst_read",  {31'd0, mgmt_read}, 32'd0);
        check("rst_write", {31'd0, mgmt_write}, 32'd0);
        check("rst_rom_addr", {30'd0, rom_addr}, 32'd0);
        check("rst_address",  {20'd0, mgmt_address}, 32'd0);
        check("rst_wdata", mgmt_writedata, 32'd0);
        rst_n = 1'b1;

        // Profile 1: seek past first profile, single RMW on channel 0
        snap();
        run(2'd1, 4'b0001, 0, lat, err, busy0);
        check("p1_lat", lat, 32'd12);
        check("p1_err", {31'd0, err}, 32'd0);
        check("p1_busy", {31'd0, busy0}, 32'd1);
        check("p1_reads", rd_acc - b_acc, 32'd1);
        check("p1_writes", wa_q.size() - b_w, 32'd1);
        check("p1_addr", {20'd0, wa_q[b_w]}, 32'h108);
        check("p1_wdata", wd_q[b_w], 32'hA3);

        // Profile 0 on channels 1 and 3
        snap();
        run(2'd0, 4'b1010, 0, lat, err, busy0);
        check("mc_lat", lat, 32'd10);
        check("mc_err", {31'd0, err}, 32'd0);
        check("mc_reads", rd_acc - b_acc, 32'd2);
        check("mc_writes", wa_q.size() - b_w, 32'd2);
        check("mc_addr0", {20'd0, wa_q[b_w]}, 32'h508);
        check("mc_wdata0", wd_q[b_w], 32'hA4);
        check("mc_addr1", {20'd0, wa_q[b_w+1]}, 32'hD08);
        check("mc_wdata1", wd_q[b_w+1], 32'hA4);

        // Full-mask entry is write-only
        rom_wo();
        snap();
        run(2'd0, 4'b0001, 0, lat, err, busy0);
        check("wo_lat", lat, 32'd7);
        check("wo_err", {31'd0, err}, 32'd0);
        check("wo_read_hi", rd_hi - b_hi, 32'd0);
        check("wo_writes", wa_q.size() - b_w, 32'd1);
        check("wo_addr", {20'd0, wa_q[b_w]}, 32'h10A);
        check("wo_wdata", wd_q[b_w], 32'h3C);

        // Stuck waitrequest on a read
        rom_rmw();
        mgmt_waitrequest = 1'b1;
        snap();
        run(2'd0, 4'b0001, 0, lat, err, busy0);
        mgmt_waitrequest = 1'b0;
        check("to_lat", lat, 32'd20);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_read_hi", rd_hi - b_hi, 32'd16);
        check("to_writes", wa_q.size() - b_w, 32'd0);
        repeat (2) @(negedge clk);
        check("to_err_held", {31'd0, cfg_error}, 32'd1);
        check("to_idle", {31'd0, cfg_busy}, 32'd0);

        // Invalid selections and ROM overrun
        snap();
        run(2'd3, 4'b0001, 0, lat, err, busy0);
        check("bad_sel_lat", lat, 32'd2);
        check("bad_sel_err", {31'd0, err}, 32'd1);
        run(2'd0, 4'b0000, 0, lat, err, busy0);
        check("zero_mask_lat", lat, 32'd2);
        check("zero_mask_err", {31'd0, err}, 32'd1);
        run(2'd2, 4'b0001, 0, lat, err, busy0);
        check("overrun_lat", lat, 32'd11);
        check("overrun_err", {31'd0, err}, 32'd1);
        check("bad_read_hi", rd_hi - b_hi, 32'd0);
        check("bad_writes", wa_q.size() - b_w, 32'd0);

        // Reset while a write is stalled
        rom_wo();
        mgmt_waitrequest = 1'b1;
        @(negedge clk);
        cfg_sel = 2'd0; cfg_ch_mask = 4'b0001; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        snap();
        repeat (4) @(negedge clk);
        check("rw_write_held", {31'd0, mgmt_write}, 32'd1);
        check("rw_addr_held", {20'd0, mgmt_address}, 32'h10A);
        #2 rst_n = 1'b0;
        #1;
        check("rw_write_drop", {31'd0, mgmt_write}, 32'd0);
        check("rw_busy_drop", {31'd0, cfg_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mgmt_waitrequest = 1'b0;
        check("rw_no_done", done_cnt - b_done, 32'd0);

        snap();
        run(2'd0, 4'b0001, 1, lat, err, busy0);
        check("rl_lat", lat, 32'd7);
        check("rl_err", {31'd0, err}, 32'd0);
        check("rl_writes", wa_q.size() - b_w, 32'd1);
        @(negedge clk);
        check("rl_done_cnt", done_cnt - b_done, 32'd1);
        check("rl_idle", {31'd0, cfg_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
